onehot_mux_pipe: RTL and testbench
==================================

// Module: onehot_mux_pipe
// PURPOSE
//  Parametrised N-way one-hot-select datapath mux with a registered output stage and a
//  2-entry elastic buffer using valid/ready handshakes on both sides.
//  Checks that each select is one-hot, counts illegal selects and substitutes a defined value.
//  Sits between pipeline stages wherever forwarding/writeback source selection must be registered.
// PARAMETERS
//  WIDTH        32  data width per input channel
//  N            4   number of input channels (2..16)
//  BAD_SEL_MODE 0   0: illegal select outputs all-zero; 1: outputs last legally selected data
//  ERRW         8   width of the saturating illegal-select counter
// PORTS
//  Clk        in   1          clock, rising edge
//  Rst_n      in   1          asynchronous active-low reset
//  In_data    in   N*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH]
//  In_sel     in   N          one-hot channel select; bit k selects channel k
//  In_valid   in   1          In_data/In_sel valid this cycle
//  In_ready   out  1          buffer can accept; transfer when In_valid && In_ready
//  Out_data   out  WIDTH      selected data, head of buffer
//  Out_idx    out  clog2(N)   binary index of selected channel (0 when select was illegal)
//  Out_bad    out  1          head entry came from an illegal select
//  Out_valid  out  1          head entry valid
//  Out_ready  in   1          consumer accepts; transfer when Out_valid && Out_ready
//  Err_sticky out  1          set on any accepted illegal select; cleared by Err_clr
//  Err_count  out  ERRW       accepted illegal selects, saturates at all-ones
//  Err_clr    in   1          synchronous clear of Err_sticky and Err_count
// BEHAVIOUR
//  - Reset (Rst_n=0, async): buffer emptied; Out_valid=0, Out_data=0, Out_idx=0, Out_bad=0,
//    In_ready=1, Err_sticky=0, Err_count=0, last-good register=0. Reset mid-transfer drops all data.
//  - Legal select: exactly one In_sel bit set. Illegal: zero bits or >1 bit set.
//  - Accept: on accept the mux result (data, idx, bad) is written into the buffer;
//    Out_valid rises the next cycle when the buffer was empty (latency 1). No combinational path In->Out.
//  - Buffer: 2 entries, strict FIFO order. In_ready = (count<2), registered-equivalent (function of count only).
//    count 0: accept -> 1. count 1: accept+drain -> 1, accept only -> 2, drain only -> 0.
//    count 2: In_ready=0, no accept; drain -> 1. No loss or duplication under any Out_ready pattern.
//  - Illegal select: BAD_SEL_MODE=0 -> data 0; =1 -> last-good register value. Out_idx=0, Out_bad=1.
//    Last-good register updates only on accepted legal selects.
//  - Error counting only on accepted transfers (In_valid&&In_ready); non-accepted illegal sel ignored.
//    Err_count saturates at 2^ERRW-1. Err_clr and an accepted illegal select in the same cycle:
//    result Err_sticky=1, Err_count=1.
//  - Out_data/Out_idx/Out_bad held stable while Out_valid && !Out_ready.
// STRUCTURE
//  - Shared package onehot_mux_pkg: clog2 function, BAD_SEL_ZERO=0 / BAD_SEL_HOLD=1 constants,
//    buffer entry layout {bad, idx, data} width constant.
//  - Sub-module elastic_buf2 (generic 2-entry valid/ready FIFO, parameter W); top holds mux,
//    one-hot checker, encoder, last-good register and error counter.
// TESTING
//  - Reset: Rst_n low mid-stream with count=2 -> all outputs zero, In_ready=1 same cycle (async).
//  - Legal sweep WIDTH=32,N=4: In_data ch0..3 = 0xA0,0xB1,0xC2,0xD3, sel 0001/0010/0100/1000, Out_ready=1
//    -> Out_data A0,B1,C2,D3, Out_idx 0..3, one cycle after each accept.
//  - Backpressure: Out_ready=0, push 3 words -> 2 accepted, In_ready=0 on third; release Out_ready
//    -> words emerge in order, third accepted once count drops to 1.
//  - Illegal, mode 0: sel=0110 -> Out_data=0, Out_bad=1, Out_idx=0, Err_sticky=1, Err_count=1.
//  - Illegal, mode 1: legal sel 0100 data 0xC2 then sel 0000 -> Out_data=0xC2, Out_bad=1.
//  - Counter: ERRW=2, four illegal accepts -> Err_count=3 (saturated); Err_clr with 5th illegal -> 1.

Source files
------------

// File: rtl/onehot_mux_pkg.sv
// rtl/onehot_mux_pkg.sv - shared constants and helpers for the one-hot select mux pipeline
package onehot_mux_pkg;

    localparam int BAD_SEL_ZERO = 0;
    localparam int BAD_SEL_HOLD = 1;

    // Index width for a value range; never below 1 so N=2 still gets a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Buffer entry layout is {bad, idx, data}.
    function automatic int entry_w(input int width, input int n);
        return 1 + clog2(n) + width;
    endfunction

endpackage

// File: rtl/elastic_buf2.sv
// rtl/elastic_buf2.sv - generic 2-entry valid/ready FIFO with registered outputs
module elastic_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Ready depends on occupancy only, so there is no path from out_ready to in_ready.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = entry0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        entry0 <= in_data;
                        count  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        entry0 <= in_data;
                    end else if (push) begin
                        entry1 <= in_data;
                        count  <= 2'd2;
                    end else if (pop) begin
                        count  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        entry0 <= entry1;
                        count  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/onehot_mux_pipe.sv
// rtl/onehot_mux_pipe.sv - one-hot select mux with illegal-select handling feeding a 2-entry elastic buffer
module onehot_mux_pipe
    import onehot_mux_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N            = 4,
    parameter int BAD_SEL_MODE = 0,
    parameter int ERRW         = 8
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [N*WIDTH-1:0]    In_data,
    input  logic [N-1:0]          In_sel,
    input  logic                  In_valid,
    output logic                  In_ready,
    output logic [WIDTH-1:0]      Out_data,
    output logic [clog2(N)-1:0]   Out_idx,
    output logic                  Out_bad,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic                  Err_sticky,
    output logic [ERRW-1:0]       Err_count,
    input  logic                  Err_clr
);

    localparam int IDXW = clog2(N);
    localparam int EW   = entry_w(WIDTH, N);

    logic             legal;
    logic             accept;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] last_good;
    logic [IDXW-1:0]  enc_idx;
    logic [EW-1:0]    entry;
    logic [EW-1:0]    head;

    assign legal  = (In_sel != '0) && ((In_sel & (In_sel - N'(1))) == '0);
    assign accept = In_valid && In_ready;

    // AND-OR mux and encoder; only trusted when the select is legal.
    always_comb begin
        mux_data = '0;
        enc_idx  = '0;
        for (int k = 0; k < N; k++) begin
            if (In_sel[k]) begin
                mux_data = mux_data | In_data[k*WIDTH +: WIDTH];
                enc_idx  = enc_idx | IDXW'(k);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        if (legal) begin
            sel_data = mux_data;
        end else if (BAD_SEL_MODE == BAD_SEL_HOLD) begin
            sel_data = last_good;
        end
    end

    assign entry = {~legal, (legal ? enc_idx : IDXW'(0)), sel_data};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_good <= '0;
        end else if (accept && legal) begin
            last_good <= mux_data;
        end
    end

    // A clear coinciding with a counted illegal select leaves that one event recorded.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Err_sticky <= 1'b0;
            Err_count  <= '0;
        end else if (accept && !legal) begin
            Err_sticky <= 1'b1;
            if (Err_clr) begin
                Err_count <= ERRW'(1);
            end else if (Err_count != {ERRW{1'b1}}) begin
                Err_count <= Err_count + ERRW'(1);
            end
        end else if (Err_clr) begin
            Err_sticky <= 1'b0;
            Err_count  <= '0;
        end
    end

    elastic_buf2 #(
        .W(EW)
    ) u_buf (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .in_data  (entry),
        .in_valid (In_valid),
        .in_ready (In_ready),
        .out_data (head),
        .out_valid(Out_valid),
        .out_ready(Out_ready)
    );

    assign {Out_bad, Out_idx, Out_data} = head;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// tb/tb_onehot_mux_pipe.sv - directed vector bench for onehot_mux_pipe in zero and hold modes
module tb_onehot_mux_pipe;

    logic         Clk;
    logic         Rst_n;
    logic [127:0] In_data;
    logic [3:0]   In_sel;
    logic         In_valid;
    logic         Out_ready;
    logic         Err_clr;

    logic         z_in_ready, z_out_bad, z_out_valid, z_err_sticky;
    logic [31:0]  z_out_data;
    logic [1:0]   z_out_idx;
    logic [1:0]   z_err_count;

    logic         h_in_ready, h_out_bad, h_out_valid, h_err_sticky;
    logic [31:0]  h_out_data;
    logic [1:0]   h_out_idx;
    logic [7:0]   h_err_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [1:0]  idx;
        logic        bad;
        logic [31:0] dz;
        logic [31:0] dh;
    } vec_t;

    vec_t tbl[7];

    onehot_mux_pipe #(.WIDTH(32), .N(4), .BAD_SEL_MODE(0), .ERRW(2)) dut_z (
        .Clk(Clk), .Rst_n(Rst_n), .In_data(In_data), .In_sel(In_sel), .In_valid(In_valid),
        .In_ready(z_in_ready), .Out_data(z_out_data), .Out_idx(z_out_idx), .Out_bad(z_out_bad),
        .Out_valid(z_out_valid), .Out_ready(Out_ready), .Err_sticky(z_err_sticky),
        .Err_count(z_err_count), .Err_clr(Err_clr)
    );

    onehot_mux_pipe #(.WIDTH(32), .N(4), .BAD_SEL_MODE(1), .ERRW(8)) dut_h (
        .Clk(Clk), .Rst_n(Rst_n), .In_data(In_data), .In_sel(In_sel), .In_valid(In_valid),
        .In_ready(h_in_ready), .Out_data(h_out_data), .Out_idx(h_out_idx), .Out_bad(h_out_bad),
        .Out_valid(h_out_valid), .Out_ready(Out_ready), .Err_sticky(h_err_sticky),
        .Err_count(h_err_count), .Err_clr(Err_clr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] sel, input logic clr);
        @(posedge Clk);
        #1;
        In_sel   = sel;
        In_valid = 1'b1;
        Err_clr  = clr;
        check("push_in_ready", z_in_ready, 1'b1);
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        Err_clr  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b0001, 2'd0, 1'b0, 32'hA0, 32'hA0};
        tbl[1] = '{4'b0010, 2'd1, 1'b0, 32'hB1, 32'hB1};
        tbl[2] = '{4'b0100, 2'd2, 1'b0, 32'hC2, 32'hC2};
        tbl[3] = '{4'b1000, 2'd3, 1'b0, 32'hD3, 32'hD3};
        tbl[4] = '{4'b0110, 2'd0, 1'b1, 32'h00, 32'hD3};
        tbl[5] = '{4'b0100, 2'd2, 1'b0, 32'hC2, 32'hC2};
        tbl[6] = '{4'b0000, 2'd0, 1'b1, 32'h00, 32'hC2};

        Rst_n     = 1'b0;
        In_data   = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
        In_sel    = 4'b0000;
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        Err_clr   = 1'b0;
        #3;
        check("rst_out_valid", z_out_valid, 1'b0);
        check("rst_out_data", z_out_data, 32'h0);
        check("rst_in_ready", z_in_ready, 1'b1);
        check("rst_err_count", z_err_count, 2'd0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Table sweep: each word accepted, checked one cycle later, drained on the next edge.
        for (int i = 0; i < 7; i++) begin
            push(tbl[i].sel, 1'b0);
            @(negedge Clk);
            check("tbl_valid", z_out_valid, 1'b1);
            check("tbl_data_zero", z_out_data, tbl[i].dz);
            check("tbl_idx", z_out_idx, tbl[i].idx);
            check("tbl_bad", z_out_bad, tbl[i].bad);
            check("tbl_data_hold", h_out_data, tbl[i].dh);
            check("tbl_bad_hold", h_out_bad, tbl[i].bad);
        end
        check("tbl_sticky", z_err_sticky, 1'b1);
        check("tbl_count_z", z_err_count, 2'd2);
        check("tbl_count_h", h_err_count, 8'd2);

        // Saturation at ERRW=2, then clear together with an illegal accept.
        push(4'b1111, 1'b0);
        @(negedge Clk);
        check("sat1_count_z", z_err_count, 2'd3);
        check("sat1_count_h", h_err_count, 8'd3);
        check("sat1_hold_data", h_out_data, 32'hC2);
        push(4'b1111, 1'b0);
        @(negedge Clk);
        check("sat2_count_z", z_err_count, 2'd3);
        check("sat2_count_h", h_err_count, 8'd4);
        push(4'b0000, 1'b1);
        @(negedge Clk);
        check("clrbad_count_z", z_err_count, 2'd1);
        check("clrbad_count_h", h_err_count, 8'd1);
        check("clrbad_sticky", z_err_sticky, 1'b1);

        // Backpressure: three words offered, third held off until a slot frees.
        @(posedge Clk);
        #1;
        Out_ready = 1'b0;
        In_sel    = 4'b0001;
        In_valid  = 1'b1;
        In_data[31:0] = 32'h11;
        check("bp_ready0", z_in_ready, 1'b1);
        check("bp_empty", z_out_valid, 1'b0);
        @(posedge Clk);
        #1 In_data[31:0] = 32'h22;
        check("bp_ready1", z_in_ready, 1'b1);
        @(posedge Clk);
        #1 In_data[31:0] = 32'h33;
        check("bp_full_ready", z_in_ready, 1'b0);
        check("bp_head", z_out_data, 32'h11);
        @(posedge Clk);
        #1;
        check("bp_still_full", z_in_ready, 1'b0);
        check("bp_head_stable", z_out_data, 32'h11);
        check("bp_valid_stable", z_out_valid, 1'b1);
        Out_ready = 1'b1;
        @(posedge Clk);
        #1;
        check("bp_second", z_out_data, 32'h22);
        check("bp_ready_again", z_in_ready, 1'b1);
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        check("bp_third", z_out_data, 32'h33);
        check("bp_third_valid", z_out_valid, 1'b1);
        @(posedge Clk);
        #1;
        check("bp_drained", z_out_valid, 1'b0);
        In_data[31:0] = 32'hA0;

        // Asynchronous reset with the buffer full.
        Out_ready = 1'b0;
        In_sel    = 4'b1000;
        In_valid  = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        check("full_head", z_out_data, 32'hD3);
        check("full_ready", z_in_ready, 1'b0);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_valid", z_out_valid, 1'b0);
        check("arst_data", z_out_data, 32'h0);
        check("arst_idx", z_out_idx, 2'd0);
        check("arst_bad", z_out_bad, 1'b0);
        check("arst_ready", z_in_ready, 1'b1);
        check("arst_sticky", h_err_sticky, 1'b0);
        check("arst_count", h_err_count, 8'd0);
        @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        Out_ready = 1'b1;

        // Last-good register must have been cleared by reset.
        push(4'b0000, 1'b0);
        @(negedge Clk);
        check("lastgood_rst_data", h_out_data, 32'h0);
        check("lastgood_rst_bad", h_out_bad, 1'b1);
        check("post_rst_count", h_err_count, 8'd1);

        // Clear on a legal accept wipes both error outputs.
        push(4'b0001, 1'b1);
        @(negedge Clk);
        check("clr_data", z_out_data, 32'hA0);
        check("clr_sticky", z_err_sticky, 1'b0);
        check("clr_count", h_err_count, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
